znmi_retn: RTL and testbench

// Monitors Z80 opcode fetches to detect when the Z80 acts on an NMI raised by znmi
// and when the NMI handler returns. It detects the acknowledge fetch at the NMI

---
 rtl/znmi_retn.sv | 140 ++++++++++++++
 tb/tb_znmi_retn.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/znmi_retn.sv
// Watches Z80 opcode fetches to see when an NMI from znmi is accepted, when its
// handler returns through RETN (or an alias), and when an armed NMI is never taken.
module znmi_retn #(
    parameter logic [15:0] ACK_ADDR = 16'h0066,
    parameter int          TIMEOUT  = 8
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        rfsh_n,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    input  logic        gen_nmi,
    output logic        nmi_taken,
    output logic        retn_seen,
    output logic        nmi_lost,
    output logic        in_handler
);

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARMED, HANDLER, ED_SEEN} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  tcnt_reg, tcnt_next;
    logic [15:0] fa_reg;
    logic [7:0]  op_reg;
    logic        fa_valid_reg;
    logic        rfsh_reg;
    logic        gen_reg;
    logic        nmi_taken_reg, retn_seen_reg, nmi_lost_reg;
    logic        taken_next, retn_next, lost_next;

    logic        fetch, fetch_done, gen_rise, op_valid, ack_hit, is_retn;
    logic [7:0]  tcnt_inc;

    assign fetch      = ~m1_n & ~mreq_n & ~rd_n;
    assign fetch_done = zneg & rfsh_reg & ~rfsh_n;
    assign gen_rise   = gen_nmi & ~gen_reg;
    // Interrupt-acknowledge M1 cycles still end in a refresh but carry no address/opcode.
    assign op_valid   = fetch_done & fa_valid_reg;
    assign ack_hit    = op_valid & (fa_reg == ACK_ADDR);
    assign tcnt_inc   = (tcnt_reg == 8'hFF) ? tcnt_reg : tcnt_reg + 8'd1;

    always_comb begin
        case (op_reg)
            8'h45, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D: is_retn = 1'b1;
            default:                                          is_retn = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
        taken_next = 1'b0;
        retn_next  = 1'b0;
        lost_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gen_rise) begin
                    state_next = ARMED;
                    tcnt_next  = 8'd0;
                end
            end
            ARMED: begin
                if (ack_hit) begin
                    state_next = HANDLER;
                    taken_next = 1'b1;
                end else if (gen_nmi) begin
                    tcnt_next = 8'd0;
                end else if (fetch_done) begin
                    tcnt_next = tcnt_inc;
                    if (tcnt_inc >= TIMEOUT_L) begin
                        state_next = IDLE;
                        lost_next  = 1'b1;
                    end
                end
            end
            HANDLER: begin
                if (op_valid && op_reg == 8'hED)
                    state_next = ED_SEEN;
            end
            ED_SEEN: begin
                if (op_valid) begin
                    if (is_retn) begin
                        state_next = IDLE;
                        retn_next  = 1'b1;
                    end else if (op_reg != 8'hED) begin
                        state_next = HANDLER;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tcnt_reg      <= 8'd0;
            fa_reg        <= 16'd0;
            op_reg        <= 8'd0;
            fa_valid_reg  <= 1'b0;
            rfsh_reg      <= 1'b0;
            gen_reg       <= 1'b0;
            nmi_taken_reg <= 1'b0;
            retn_seen_reg <= 1'b0;
            nmi_lost_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tcnt_reg      <= tcnt_next;
            gen_reg       <= gen_nmi;
            nmi_taken_reg <= taken_next;
            retn_seen_reg <= retn_next;
            nmi_lost_reg  <= lost_next;
            if (zneg)
                rfsh_reg <= rfsh_n;
            if (fetch_done)
                fa_valid_reg <= 1'b0;
            // Address is captured once per fetch; opcode follows every qualifying zpos.
            if (zpos && fetch) begin
                op_reg <= d;
                if (!fa_valid_reg) begin
                    fa_reg       <= a;
                    fa_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign nmi_taken  = nmi_taken_reg;
    assign retn_seen  = retn_seen_reg;
    assign nmi_lost   = nmi_lost_reg;
    assign in_handler = (state_reg == HANDLER) || (state_reg == ED_SEEN);

endmodule

// File: tb/tb_znmi_retn.sv
// Bench for znmi_retn: directed NMI/RETN scenarios followed by random fetch traffic,
// checked every fclk against a transaction-level model of the NMI lifecycle.
module tb_znmi_retn;

    logic        fclk = 1'b0;
    logic        rst, zpos, zneg, m1_n, mreq_n, rd_n, rfsh_n, gen_nmi;
    logic [15:0] a;
    logic [7:0]  d;
    logic        nmi_taken, retn_seen, nmi_lost, in_handler;
    logic [3:0]  obs, exp_v;

    int checks = 0;
    int errors = 0;

    // Reference model: NMI lifecycle tracked per transaction.
    bit m_armed, m_hand, m_ed, m_gen;
    int m_tcnt;

    logic [7:0] ops [12];

    znmi_retn dut (
        .fclk(fclk), .rst(rst), .zpos(zpos), .zneg(zneg), .m1_n(m1_n),
        .mreq_n(mreq_n), .rd_n(rd_n), .rfsh_n(rfsh_n), .a(a), .d(d),
        .gen_nmi(gen_nmi), .nmi_taken(nmi_taken), .retn_seen(retn_seen),
        .nmi_lost(nmi_lost), .in_handler(in_handler)
    );

    assign obs = {nmi_taken, retn_seen, nmi_lost, in_handler};

    always #5 fclk = ~fclk;

    task automatic step(input string tag);
        @(posedge fclk);
        @(negedge fclk);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs(tk,rt,lo,ih)=%b exp=%b t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic idle_inputs();
        zpos = 1'b0; zneg = 1'b0; m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic idle_step();
        idle_inputs();
        exp_v = {3'b000, m_hand};
        step("idle");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gen_nmi = 1'b0;
        idle_inputs();
        m_armed = 0; m_hand = 0; m_ed = 0; m_gen = 0; m_tcnt = 0;
        exp_v = 4'b0000;
        step("reset");
        rst = 1'b0;
        step("post_reset");
        $display("reset: outputs %b", obs);
    endtask

    task automatic set_gen(input bit v);
        gen_nmi = v;
        idle_inputs();
        if (v && !m_gen && !m_armed && !m_hand) begin
            m_armed = 1;
            m_tcnt  = 0;
        end
        if (v && m_armed) m_tcnt = 0;
        m_gen = v;
        exp_v = {3'b000, m_hand};
        step("gen_nmi");
        $display("gen_nmi=%0b armed=%0b handler=%0b", v, m_armed, m_hand);
    endtask

    // One M1 cycle: address/opcode on zpos, then refresh falls and is seen on zneg.
    task automatic fetch(input logic [15:0] addr, input logic [7:0] op, input bit intack);
        bit t, r, l;
        t = 0; r = 0; l = 0;
        exp_v = {3'b000, m_hand};
        m1_n = 1'b0; mreq_n = intack; rd_n = intack; a = addr; d = op;
        zpos = 1'b1; zneg = 1'b0;
        step("fetch_t1");
        zpos = 1'b0; zneg = 1'b1;
        step("fetch_t2");
        m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; rfsh_n = 1'b0; zpos = 1'b1; zneg = 1'b0;
        step("fetch_t3");
        if (m_armed) begin
            if (!intack && addr == 16'h0066) begin
                m_armed = 0; m_hand = 1; m_ed = 0; t = 1;
            end else if (m_gen) begin
                m_tcnt = 0;
            end else begin
                m_tcnt++;
                if (m_tcnt >= 8) begin
                    m_armed = 0; l = 1;
                end
            end
        end else if (m_hand && !intack) begin
            if (m_ed) begin
                if (op inside {8'h45, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D}) begin
                    m_hand = 0; m_ed = 0; r = 1;
                end else if (op != 8'hED) begin
                    m_ed = 0;
                end
            end else if (op == 8'hED) begin
                m_ed = 1;
            end
        end
        zpos = 1'b0; zneg = 1'b1;
        exp_v = {t, r, l, m_hand};
        step("fetch_done_pulse");
        zneg = 1'b0;
        exp_v = {3'b000, m_hand};
        step("fetch_after");
        rfsh_n = 1'b1; zneg = 1'b1;
        step("fetch_rfsh_hi");
        zneg = 1'b0;
        step("fetch_end");
        $display("fetch a=%h op=%h intack=%0b -> tk=%0b rt=%0b lo=%0b ih=%0b",
                 addr, op, intack, nmi_taken, retn_seen, nmi_lost, in_handler);
    endtask

    task automatic arm_and_take();
        set_gen(1'b1);
        set_gen(1'b0);
        fetch(16'h0066, 8'h00, 1'b0);
    endtask

    initial begin
        logic [15:0] addr;
        int          r;
        ops = '{8'hED, 8'hED, 8'h45, 8'h4D, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D, 8'h00, 8'h00};
        a = 16'h0000; d = 8'h00;
        do_reset();

        // Long NMI, then the acknowledge fetch at the vector.
        set_gen(1'b1);
        repeat (31) idle_step();
        fetch(16'h0066, 8'hF5, 1'b0);
        set_gen(1'b0);
        // RETN
        fetch(16'h0100, 8'hED, 1'b0);
        fetch(16'h0101, 8'h45, 1'b0);
        // ED ED 45
        arm_and_take();
        fetch(16'h0100, 8'hED, 1'b0);
        fetch(16'h0101, 8'hED, 1'b0);
        fetch(16'h0102, 8'h45, 1'b0);
        // RETI is not a return; nested vector fetch ignored
        arm_and_take();
        fetch(16'h0100, 8'hED, 1'b0);
        fetch(16'h0101, 8'h4D, 1'b0);
        fetch(16'h0066, 8'h00, 1'b0);
        fetch(16'h0102, 8'hED, 1'b0);
        fetch(16'h0103, 8'h7D, 1'b0);
        // Timeout after 8 fetches elsewhere
        set_gen(1'b1);
        set_gen(1'b0);
        repeat (8) fetch(16'h1234, 8'h00, 1'b0);
        // Intack cycle at the vector is not an ack but does count toward the timeout
        set_gen(1'b1);
        set_gen(1'b0);
        fetch(16'h0066, 8'hFF, 1'b1);
        repeat (7) fetch(16'h1234, 8'h00, 1'b0);
        // Reset while in ED_SEEN
        arm_and_take();
        fetch(16'h0100, 8'hED, 1'b0);
        do_reset();
        fetch(16'h0101, 8'h45, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                set_gen(1'b1);
                repeat ($urandom_range(0, 5)) idle_step();
                set_gen(1'b0);
            end else if (r < 17) begin
                do_reset();
            end else if (r < 25) begin
                set_gen(~m_gen);
            end else begin
                r = $urandom_range(0, 9);
                addr = (r < 4) ? 16'h0066 : (r < 7) ? 16'h1234 : 16'($urandom);
                fetch(addr, ops[$urandom_range(0, 11)], $urandom_range(0, 9) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
